// File: rtl/mem_resp_pkg.sv
// Shared types, limits and byte-merge helper for the memory-bus responder.
package mem_resp_pkg;

    localparam int unsigned MEM_RESP_DW          = 32;
    localparam int unsigned MEM_RESP_MAX_LATENCY = 31;

    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [MEM_RESP_DW-1:0] rdata;
    } mem_resp_t;

    // Replace the byte lanes of old selected by be with the matching lanes of wdata.
    function automatic logic [MEM_RESP_DW-1:0] be_merge(
        input logic [MEM_RESP_DW-1:0]   old,
        input logic [MEM_RESP_DW-1:0]   wdata,
        input logic [MEM_RESP_DW/8-1:0] be
    );
        logic [MEM_RESP_DW-1:0] res;
        for (int i = 0; i < int'(MEM_RESP_DW / 8); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                res[8*i +: 8] = old[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_resp_delay.sv
// Response delay line: STAGES register stages with synchronous active-low clear;
// a plain wire when STAGES is 0.
module mem_resp_delay
    import mem_resp_pkg::*;
#(
    parameter int unsigned STAGES = 0,
    parameter type         T      = mem_resp_t
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  T     i_data,
    output T     o_data
);

    generate
        if (STAGES == 0) begin : g_wire
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst_n};
            assign o_data   = i_data;
        end else begin : g_pipe
            T r_pipe [STAGES];

            // Shift the response one stage per cycle; clearing drops everything in flight.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < int'(STAGES); i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_data;
                    for (int i = 1; i < int'(STAGES); i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_data = r_pipe[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// On-chip byte-enabled memory answering the unified memory bus after a fixed latency.
// Optional feature macro: MEM_RESP_ERR_EN (out-of-range accesses respond with err=1).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned MEM_W     = 32,
    parameter int unsigned MEM_SIZE  = 65536,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned LATENCY   = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mem_req_i,
    input  logic [31:0]        mem_addr_i,
    input  logic               mem_we_i,
    input  logic [MEM_W/8-1:0] mem_be_i,
    input  logic [MEM_W-1:0]   mem_wdata_i,
    output logic               mem_rvalid_o,
    output logic               mem_err_o,
    output logic [MEM_W-1:0]   mem_rdata_o
);

    localparam int unsigned BYTES  = MEM_W / 8;
    localparam int unsigned WORDS  = MEM_SIZE / BYTES;
    localparam int unsigned LSB    = $clog2(BYTES);
    localparam int unsigned AW     = $clog2(MEM_SIZE);
    localparam int unsigned CHUNKS = MEM_W / MEM_RESP_DW;

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [MEM_W-1:0] rdata;
    } resp_t;

    generate
        if (MEM_W < 32 || (MEM_W & (MEM_W - 1)) != 0) begin : g_bad_width
            $error("mem_responder: MEM_W must be a power of two >= 32");
        end
        if ((MEM_SIZE & (MEM_SIZE - 1)) != 0 || MEM_SIZE <= BYTES) begin : g_bad_size
            $error("mem_responder: MEM_SIZE must be a power of two holding at least two words");
        end
        if (LATENCY < 1 || LATENCY > MEM_RESP_MAX_LATENCY) begin : g_bad_latency
            $error("mem_responder: LATENCY out of range 1..31");
        end
    endgenerate

    logic [MEM_W-1:0]    r_mem [WORDS];
    logic [31:0]         w_off;
    logic [AW-LSB-1:0]   w_idx;
    logic                w_oor;
    logic                w_wr_en;
    logic [MEM_W-1:0]    w_rd_word;
    logic [MEM_W-1:0]    w_wr_word;
    logic                w_unused_off;
    resp_t               r_stage0;
    resp_t               w_resp_out;

    // Offset wraps naturally, so addresses below the base look like huge offsets.
    assign w_off        = mem_addr_i - BASE_ADDR;
    assign w_idx        = w_off[AW-1:LSB];
    assign w_unused_off = ^{w_off[LSB-1:0], w_off[31:AW]};

`ifdef MEM_RESP_ERR_EN
    assign w_oor = (w_off >= MEM_SIZE);
`else
    assign w_oor = 1'b0;
`endif

    assign w_wr_en = rst_ni & mem_req_i & mem_we_i & ~w_oor;

    // Read the addressed word and build its byte-merged replacement.
    always_comb begin
        w_rd_word = r_mem[w_idx];
        w_wr_word = w_rd_word;
        for (int c = 0; c < int'(CHUNKS); c++) begin
            w_wr_word[c*MEM_RESP_DW +: MEM_RESP_DW] = be_merge(
                w_rd_word[c*MEM_RESP_DW +: MEM_RESP_DW],
                mem_wdata_i[c*MEM_RESP_DW +: MEM_RESP_DW],
                mem_be_i[c*(MEM_RESP_DW/8) +: (MEM_RESP_DW/8)]);
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    // Stage 0 snapshots the response at acceptance so later writes cannot alter it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stage0 <= '0;
        end else begin
            r_stage0.valid <= mem_req_i;
            r_stage0.err   <= mem_req_i & w_oor;
            r_stage0.rdata <= (mem_req_i && !mem_we_i && !w_oor) ? w_rd_word : '0;
        end
    end

    mem_resp_delay #(
        .STAGES (LATENCY - 1),
        .T      (resp_t)
    ) u_delay (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_data  (r_stage0),
        .o_data  (w_resp_out)
    );

    assign mem_rvalid_o = w_resp_out.valid;
    assign mem_err_o    = w_resp_out.err;
    assign mem_rdata_o  = w_resp_out.rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: byte-array reference model with a due-cycle response queue.
module tb_mem_responder;

    localparam int unsigned LAT  = 4;
    localparam int unsigned SIZE = 65536;
    localparam logic [31:0] BASE = 32'h0;
`ifdef MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_req_i;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wdata_i;
    logic        mem_rvalid_o;
    logic        mem_err_o;
    logic [31:0] mem_rdata_o;

    always #5 clk_i = ~clk_i;

    mem_responder #(
        .MEM_W     (32),
        .MEM_SIZE  (SIZE),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mem_req_i    (mem_req_i),
        .mem_addr_i   (mem_addr_i),
        .mem_we_i     (mem_we_i),
        .mem_be_i     (mem_be_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_rvalid_o (mem_rvalid_o),
        .mem_err_o    (mem_err_o),
        .mem_rdata_o  (mem_rdata_o)
    );

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    byte unsigned mdl [SIZE];
    exp_t         q [$];
    int           cyc      = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit rst_n, input bit req, input logic [31:0] addr,
                        input bit we, input logic [3:0] be, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] off;
        int          wb;
        rst_ni      = rst_n;
        mem_req_i   = req;
        mem_addr_i  = addr;
        mem_we_i    = we;
        mem_be_i    = be;
        mem_wdata_i = wd;
        @(posedge clk_i);
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else if (req) begin
            off     = addr - BASE;
            e.due   = cyc + int'(LAT) - 1;
            e.err   = 1'b0;
            e.rdata = 32'h0;
            if (ERR_EN && off >= SIZE) begin
                e.err = 1'b1;
            end else begin
                wb = int'(off % SIZE) & ~3;
                if (we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) mdl[wb+i] = wd[8*i +: 8];
                    end
                end else begin
                    e.rdata = {mdl[wb+3], mdl[wb+2], mdl[wb+1], mdl[wb]};
                end
            end
            q.push_back(e);
        end
        @(negedge clk_i);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rvalid", 32'(mem_rvalid_o), 32'd1);
            chk("err", 32'(mem_err_o), 32'(q[0].err));
            chk("rdata", mem_rdata_o, q[0].rdata);
            void'(q.pop_front());
        end else begin
            chk("rvalid_idle", 32'(mem_rvalid_o), 32'd0);
            chk("err_idle", 32'(mem_err_o), 32'd0);
            chk("rdata_idle", mem_rdata_o, 32'h0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

        for (int w = 0; w < 256; w++) begin
            step(1'b1, 1'b1, 32'(w * 4), 1'b1, 4'hF, $urandom);
        end
        idle(int'(LAT));

        // Reset while a read to 0x80 is in flight
        step(1'b1, 1'b1, 32'h80, 1'b0, 4'h0, 32'h0);
        idle(1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        idle(6);

        // Write then read the same word on the next cycle
        step(1'b1, 1'b1, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF);
        step(1'b1, 1'b1, 32'h100, 1'b0, 4'h0, 32'h0);
        idle(int'(LAT) + 1);

        // Partial byte-enable write, unaligned read
        step(1'b1, 1'b1, 32'h200, 1'b1, 4'hF, 32'h11223344);
        step(1'b1, 1'b1, 32'h200, 1'b1, 4'b0101, 32'hAABBCCDD);
        step(1'b1, 1'b1, 32'h202, 1'b0, 4'h0, 32'h0);
        idle(int'(LAT) + 1);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(i * 4), 1'b0, 4'h0, 32'h0);
        idle(int'(LAT) + 1);

        // Read snapshot must not see the following write
        step(1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 32'h1);
        step(1'b1, 1'b1, 32'h40, 1'b0, 4'h0, 32'h0);
        step(1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 32'h2);
        step(1'b1, 1'b1, 32'h40, 1'b0, 4'h0, 32'h0);
        idle(int'(LAT) + 1);

        // Past-the-end write and read, then word 0
        step(1'b1, 1'b1, 32'h10000, 1'b1, 4'hF, 32'hCAFEF00D);
        step(1'b1, 1'b1, 32'h10000, 1'b0, 4'h0, 32'h0);
        step(1'b1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
        idle(int'(LAT) + 1);

        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 99));
            a = 32'($urandom_range(0, 32'h3FF));
            if ($urandom_range(0, 9) == 0) a = a + 32'h10000;
            if (r < 2) begin
                step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            end else begin
                step(1'b1, r < 75, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            end
        end
        idle(int'(LAT) + 2);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
